// File: rtl/hilo_ctrl.sv
// HI/LO register controller: MTHI/MTLO, multi-cycle divide handshake and an
// optional single-cycle multiplier compiled in by defining HILO_MULT_EN.
module hilo_ctrl (
   input  logic        clock,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_start,
   output logic        div_signed,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic        div_busy,
   output logic        dz
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_ARM,
      S_WAIT
   } state_t;

   state_t state, state_nxt;

   logic is_div;
   logic idle_op;
   logic div_go;
   logic div_zero;
   logic mt_hi;
   logic mt_lo;
   logic capture;

   // resetn gates the decode so the combinational outputs read zero during reset
   always_comb begin
      is_div   = (op == 3'b000) || (op == 3'b001);
      idle_op  = (state == S_IDLE) && op_valid && resetn;
      div_go   = idle_op && is_div && (rt_val != '0);
      div_zero = idle_op && is_div && (rt_val == '0);
      mt_hi    = idle_op && (op == 3'b010);
      mt_lo    = idle_op && (op == 3'b011);
      capture  = (state == S_WAIT) && !div_busy;
   end

`ifdef HILO_MULT_EN
   logic        mult_go;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] prod;

   // Low 64 bits of a 64x64 product of sign/zero-extended operands equal the
   // signed/unsigned 32x32 product, so one multiplier serves both MULT and MULTU.
   always_comb begin
      mult_go = idle_op && (op[2:1] == 2'b10);
      mul_a   = op[0] ? {32'b0, rs_val} : {{32{rs_val[31]}}, rs_val};
      mul_b   = op[0] ? {32'b0, rt_val} : {{32{rt_val[31]}}, rt_val};
      prod    = mul_a * mul_b;
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (div_go) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_ARM;
         S_ARM:    state_nxt = S_WAIT;
         S_WAIT:   if (!div_busy) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      stall     = div_go
                | (state == S_LAUNCH)
                | (state == S_ARM)
                | ((state == S_WAIT) && div_busy);
      div_start = (state == S_LAUNCH);
      dz        = div_zero;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         div_a      <= '0;
         div_b      <= '0;
         div_signed <= 1'b0;
      end else if (div_go) begin
         div_a      <= rs_val;
         div_b      <= rt_val;
         div_signed <= (op == 3'b000);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hi <= '0;
         lo <= '0;
      end else if (capture) begin
         hi <= div_r;
         lo <= div_q;
      end else if (mt_hi) begin
         hi <= rs_val;
      end else if (mt_lo) begin
         lo <= rs_val;
`ifdef HILO_MULT_EN
      end else if (mult_go) begin
         hi <= prod[63:32];
         lo <= prod[31:0];
`endif
      end
   end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 op_valid  in  1  EX-stage HI/LO operation present this cycle.
REQ-004 op  in  3  000 DIV, 001 DIVU, 010 MTHI, 011 MTLO, 100 MULT, 101 MULTU; others are NOP.
REQ-005 rs_val, rt_val  in  32 each  operands; dividend/multiplicand is rs_val, divisor/multiplier is rt_val.
REQ-006 stall  out  1  holds the pipeline while a divide is in flight.
REQ-007 hi, lo  out  32 each  architectural HI/LO registers.
REQ-008 div_a, div_b  out  32 each  registered operands to the divider.
REQ-009 div_start  out  1  one-cycle divider launch pulse.
REQ-010 div_signed  out  1  1 = signed divider path (DIV), 0 = unsigned (DIVU).
REQ-011 div_q, div_r, div_busy  in  32, 32, 1  divider quotient, remainder and busy flag.
REQ-012 dz  out  1  one-cycle pulse on a divide-by-zero request.

Function
REQ-013 States: IDLE, LAUNCH, ARM, WAIT; op_valid is sampled only in IDLE.
REQ-014 IDLE + op_valid + DIV/DIVU + rt_val!=0: latch div_a=rs_val, div_b=rt_val and div_signed; go to LAUNCH.
REQ-015 LAUNCH: div_start=1 for exactly this cycle; next state ARM.
REQ-016 ARM: div_busy ignored (covers divider busy-rise latency); next state WAIT.
REQ-017 WAIT: stay while div_busy=1; on first cycle div_busy=0, capture LO<=div_q and HI<=div_r at that edge; go to IDLE.
REQ-018 stall = (IDLE & op_valid & divide accepted per REQ-014) | LAUNCH | ARM | (WAIT & div_busy); stall is combinational.
REQ-019 stall drops in the final WAIT cycle so the divide instruction retires on the same edge that writes HI/LO; the next instruction sees the new HI/LO.
REQ-020 IDLE + op_valid + DIV/DIVU + rt_val==0: no launch, no stall, HI/LO unchanged, dz=1 for that cycle only.
REQ-021 IDLE + op_valid + MTHI: HI<=rs_val at next edge; MTLO: LO<=rs_val; no stall; state stays IDLE.
REQ-022 op_valid with op 110/111: no effect.
REQ-023 div_a, div_b and div_signed hold their values from LAUNCH until the next accepted divide.
REQ-024 div_q/div_r are consumed only per REQ-017; divider activity in any other state does not change HI/LO.

Reset
REQ-025 resetn=0 immediately forces: state IDLE, hi=0, lo=0, div_a=0, div_b=0, div_signed=0, div_start=0, dz=0, stall=0.
REQ-026 Reset during LAUNCH/ARM/WAIT abandons the divide; a later falling div_busy does not write HI/LO.
REQ-027 First accepted op is the first op_valid sampled on a rising edge after resetn deasserts.

Configuration
REQ-028 Macro HILO_MULT_EN compiles in the single-cycle multiplier.
REQ-029 With HILO_MULT_EN: in IDLE, MULT (signed) or MULTU (unsigned) computes the 64-bit rs_val*rt_val; {HI,LO} are written at the next edge; no stall.
REQ-030 Without HILO_MULT_EN: MULT/MULTU are NOPs; HI/LO unchanged; no stall, no dz.

Verification
REQ-031 DIV rs=0xFFFFFFF9 (-7), rt=2 -> div_start one pulse, div_signed=1, stall high until busy falls; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU rs=0xFFFFFFFF, rt=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F; stall low in the capture cycle.
REQ-033 DIV rt=0 with HI=0x11, LO=0x22 -> dz one cycle, no div_start, stall 0, HI/LO unchanged.
REQ-034 resetn low for 1 cycle mid-WAIT -> all outputs 0, state IDLE; subsequent busy fall leaves HI=LO=0.
REQ-035 DIVU 100/7 followed next cycle by MTLO 0xABCD -> HI=2, LO=14 after divide; MTLO accepted only after stall drops; LO=0xABCD one cycle later.
REQ-036 MULT 0xFFFFFFFF x 2: with HILO_MULT_EN -> HI=0xFFFFFFFF, LO=0xFFFFFFFE next cycle; without it -> HI/LO unchanged.
